hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: tracks E/M/W destination records,
// drives forwarding selects, D-stage stall and the mult/div busy window.
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] wa_D,
  input  logic [1:0] src_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  input  logic       flush,
  output logic       stall,
  output logic [3:0] selRsD,
  output logic [3:0] selRtD,
  output logic [3:0] selRsE,
  output logic [3:0] selRtE,
  output logic [3:0] selRtM,
  output logic       md_busy
);

  localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_PC8 = 2'd1;
  localparam logic [1:0] SRC_MD  = 2'd2;
  localparam logic [1:0] SRC_MEM = 2'd3;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic [1:0] src;
    logic [1:0] tnew;
    logic       md_start;
    logic       md_div;
  } e_rec_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] wa;
    logic [1:0] src;
    logic [1:0] tnew;
  } m_rec_t;

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] src;
  } w_rec_t;

  e_rec_t           e_q, e_d;
  m_rec_t           m_q, m_d;
  w_rec_t           w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [1:0] tnew_of(input logic [1:0] src);
    case (src)
      SRC_ALU: tnew_of = 2'd1;
      SRC_MEM: tnew_of = 2'd2;
      default: tnew_of = 2'd0;
    endcase
  endfunction

  // Operand X is not ready in time if a producer in E or M delivers too late.
  function automatic logic data_hz(input logic [4:0] idx, input logic [1:0] tuse,
                                   input e_rec_t e, input m_rec_t m);
    data_hz = 1'b0;
    if (idx != 5'd0 && tuse != 2'd3) begin
      data_hz = ((e.wa == idx) && (e.tnew > tuse)) ||
                ((m.wa == idx) && (m.tnew > tuse));
    end
  endfunction

  function automatic logic [3:0] fwd_d(input logic [4:0] idx, input e_rec_t e,
                                       input m_rec_t m, input w_rec_t w);
    fwd_d = 4'd0;
    if (idx == 5'd0) begin
      fwd_d = 4'd0;
    end else if (e.wa == idx) begin
      if (e.tnew == 2'd0) begin
        case (e.src)
          SRC_PC8: fwd_d = 4'd1;
          SRC_MD:  fwd_d = 4'd6;
          default: fwd_d = 4'd0;
        endcase
      end
    end else if (m.wa == idx) begin
      if (m.tnew == 2'd0) begin
        case (m.src)
          SRC_PC8: fwd_d = 4'd2;
          SRC_ALU: fwd_d = 4'd3;
          SRC_MD:  fwd_d = 4'd7;
          default: fwd_d = 4'd0;
        endcase
      end
    end else if (w.wa == idx) begin
      fwd_d = (w.src == SRC_PC8) ? 4'd4 : 4'd5;
    end
  endfunction

  function automatic logic [3:0] fwd_e(input logic [4:0] idx, input m_rec_t m,
                                       input w_rec_t w);
    fwd_e = 4'd0;
    if (idx == 5'd0) begin
      fwd_e = 4'd0;
    end else if (m.wa == idx) begin
      if (m.tnew == 2'd0) begin
        case (m.src)
          SRC_PC8: fwd_e = 4'd1;
          SRC_ALU: fwd_e = 4'd2;
          SRC_MD:  fwd_e = 4'd5;
          default: fwd_e = 4'd0;
        endcase
      end
    end else if (w.wa == idx) begin
      fwd_e = (w.src == SRC_PC8) ? 4'd3 : 4'd4;
    end
  endfunction

  // Hazard detection and forwarding are purely combinational from the records.
  always_comb begin : hazard_comb
    md_busy = e_q.md_start | (cnt_q != '0);
    stall   = data_hz(rs_D, tuse_rs_D, e_q, m_q) |
              data_hz(rt_D, tuse_rt_D, e_q, m_q) |
              (md_use_D & md_busy);
    selRsD  = fwd_d(rs_D, e_q, m_q, w_q);
    selRtD  = fwd_d(rt_D, e_q, m_q, w_q);
    selRsE  = fwd_e(e_q.rs, m_q, w_q);
    selRtE  = fwd_e(e_q.rt, m_q, w_q);
    selRtM  = 4'd0;
    if (m_q.rt != 5'd0 && w_q.wa == m_q.rt) begin
      selRtM = (w_q.src == SRC_PC8) ? 4'd1 : 4'd2;
    end
  end

  // Stage advance; a stall bubbles E, a flush bubbles every stage.
  always_comb begin : stage_next
    e_d = '0;
    m_d = '0;
    w_d = '0;
    if (!flush) begin
      if (!stall) begin
        e_d.rs       = rs_D;
        e_d.rt       = rt_D;
        e_d.wa       = wa_D;
        e_d.src      = src_D;
        e_d.tnew     = tnew_of(src_D);
        e_d.md_start = md_start_D;
        e_d.md_div   = md_div_D;
      end
      m_d.rt   = e_q.rt;
      m_d.wa   = e_q.wa;
      m_d.src  = e_q.src;
      m_d.tnew = (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0;
      w_d.wa   = m_q.wa;
      w_d.src  = m_q.src;
    end
  end

  always_comb begin : md_cnt_next
    cnt_d = cnt_q;
    if (e_q.md_start) begin
      cnt_d = e_q.md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver queues hand-computed output
// vectors per cycle, a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D, wa_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, src_D;
  logic       md_start_D, md_div_D, md_use_D, flush;
  logic       stall, md_busy;
  logic [3:0] selRsD, selRtD, selRsE, selRtE, selRtM;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .wa_D(wa_D), .src_D(src_D), .md_start_D(md_start_D), .md_div_D(md_div_D),
    .md_use_D(md_use_D), .flush(flush),
    .stall(stall), .selRsD(selRsD), .selRtD(selRtD), .selRsE(selRsE),
    .selRtE(selRtE), .selRtM(selRtM), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [21:0] e;
  } exp_t;

  exp_t        q[$];
  string       qn[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        ent;
  string       nm;
  logic [21:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  // {stall, selRsD, selRtD, selRsE, selRtE, selRtM, md_busy}
  function automatic logic [21:0] pk(input int st, input int a, input int b,
                                     input int c, input int d, input int e,
                                     input int bz);
    return {1'(st), 4'(a), 4'(b), 4'(c), 4'(d), 4'(e), 1'(bz)};
  endfunction

  task automatic drv(input int rs, input int rt, input int trs, input int trt,
                     input int wa, input int src, input int ms, input int md,
                     input int mu, input int fl);
    @(posedge clk);
    #1;
    rs_D       = 5'(rs);
    rt_D       = 5'(rt);
    tuse_rs_D  = 2'(trs);
    tuse_rt_D  = 2'(trt);
    wa_D       = 5'(wa);
    src_D      = 2'(src);
    md_start_D = 1'(ms);
    md_div_D   = 1'(md);
    md_use_D   = 1'(mu);
    flush      = 1'(fl);
  endtask

  task automatic nop();
    drv(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  task automatic chk(input string name, input logic [21:0] e);
    q.push_back('{cyc: cyc, e: e});
    qn.push_back(name);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      ent = q.pop_front();
      nm  = qn.pop_front();
      act = {stall, selRsD, selRtD, selRsE, selRtE, selRtM, md_busy};
      n_cmp++;
      if (ent.cyc != cyc || act != ent.e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, ent.e, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    rs_D = '0; rt_D = '0; wa_D = '0; src_D = '0;
    tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b0; flush = 1'b0;
    nop(); nop();
    chk("reset", pk(0, 0, 0, 0, 0, 0, 0));
    nop();
    reset = 1'b0;
    nops(3);

    // load-use: lw $1; add $2,$1,$3
    drv(2, 0, 1, 3, 1, 3, 0, 0, 0, 0); chk("lw_issue", pk(0, 0, 0, 0, 0, 0, 0));
    drv(1, 3, 1, 1, 2, 0, 0, 0, 0, 0); chk("lw_use_stall", pk(1, 0, 0, 0, 0, 0, 0));
    drv(1, 3, 1, 1, 2, 0, 0, 0, 0, 0); chk("lw_use_release", pk(0, 0, 0, 0, 0, 0, 0));
    nop();                             chk("lw_use_fwdE", pk(0, 0, 0, 4, 0, 0, 0));
    nops(4);

    // jal; jr $31
    drv(0, 0, 3, 3, 31, 1, 0, 0, 0, 0); chk("jal_issue", pk(0, 0, 0, 0, 0, 0, 0));
    drv(31, 0, 0, 3, 0, 0, 0, 0, 0, 0); chk("jr_fwdD", pk(0, 1, 0, 0, 0, 0, 0));
    nop();                              chk("jr_fwdE", pk(0, 0, 0, 1, 0, 0, 0));
    nops(4);

    // addu $4; beq $4,$0
    drv(5, 6, 1, 1, 4, 0, 0, 0, 0, 0); chk("addu_issue", pk(0, 0, 0, 0, 0, 0, 0));
    drv(4, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("beq_stall", pk(1, 0, 0, 0, 0, 0, 0));
    drv(4, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("beq_fwdD_M", pk(0, 3, 0, 0, 0, 0, 0));
    nops(4);
    // writes to $0 never forward or stall
    drv(5, 6, 1, 1, 0, 0, 0, 0, 0, 0); chk("zero_issue", pk(0, 0, 0, 0, 0, 0, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("zero_no_stall", pk(0, 0, 0, 0, 0, 0, 0));
    nops(4);

    // mult; mflo $7 -> 6 stall cycles
    drv(0, 0, 3, 3, 0, 0, 1, 0, 1, 0); chk("mult_issue", pk(0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 6; i++) begin
      drv(0, 0, 3, 3, 7, 2, 0, 0, 1, 0); chk($sformatf("mult_busy%0d", i), pk(1, 0, 0, 0, 0, 0, 1));
    end
    drv(0, 0, 3, 3, 7, 2, 0, 0, 1, 0); chk("mult_done", pk(0, 0, 0, 0, 0, 0, 0));
    drv(7, 0, 1, 3, 8, 0, 0, 0, 0, 0); chk("mflo_fwdD_E", pk(0, 6, 0, 0, 0, 0, 0));
    nop();                             chk("mflo_fwdE_M", pk(0, 0, 0, 5, 0, 0, 0));
    nops(4);

    // div; mflo -> 11 stall cycles
    drv(0, 0, 3, 3, 0, 0, 1, 1, 1, 0); chk("div_issue", pk(0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 11; i++) begin
      drv(0, 0, 3, 3, 7, 2, 0, 0, 1, 0); chk($sformatf("div_busy%0d", i), pk(1, 0, 0, 0, 0, 0, 1));
    end
    drv(0, 0, 3, 3, 7, 2, 0, 0, 1, 0); chk("div_done", pk(0, 0, 0, 0, 0, 0, 0));
    nops(4);

    // stalled mult must not start the counter until it really enters E
    drv(0, 0, 3, 3, 1, 3, 0, 0, 0, 0); chk("smd_lw", pk(0, 0, 0, 0, 0, 0, 0));
    drv(1, 0, 1, 3, 0, 0, 1, 0, 1, 0); chk("smd_stall", pk(1, 0, 0, 0, 0, 0, 0));
    drv(1, 0, 1, 3, 0, 0, 1, 0, 1, 0); chk("smd_no_load", pk(0, 0, 0, 0, 0, 0, 0));
    nop();                             chk("smd_start", pk(0, 0, 0, 4, 0, 0, 1));
    nops(8);

    // lw $5; sw $5
    drv(0, 0, 3, 3, 5, 3, 0, 0, 0, 0); chk("sw_lw_issue", pk(0, 0, 0, 0, 0, 0, 0));
    drv(0, 5, 3, 2, 0, 0, 0, 0, 0, 0); chk("sw_no_stall", pk(0, 0, 0, 0, 0, 0, 0));
    nop();                             chk("sw_in_E", pk(0, 0, 0, 0, 0, 0, 0));
    nop();                             chk("sw_fwdM", pk(0, 0, 0, 0, 0, 2, 0));
    nops(4);

    // flush with lw $1 in E and add $1 in D
    drv(0, 0, 3, 3, 1, 3, 0, 0, 0, 0); chk("fl_lw", pk(0, 0, 0, 0, 0, 0, 0));
    drv(1, 0, 1, 3, 1, 0, 0, 0, 0, 1); chk("fl_stall", pk(1, 0, 0, 0, 0, 0, 0));
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); chk("fl_empty1", pk(0, 0, 0, 0, 0, 0, 0));
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); chk("fl_empty2", pk(0, 0, 0, 0, 0, 0, 0));
    nops(2);

    // reset in the middle of a divide
    drv(0, 0, 3, 3, 0, 0, 1, 1, 1, 0); chk("rst_div_issue", pk(0, 0, 0, 0, 0, 0, 0));
    nop();                             chk("rst_div_E", pk(0, 0, 0, 0, 0, 0, 1));
    nop();                             chk("rst_div_cnt", pk(0, 0, 0, 0, 0, 0, 1));
    drv(0, 0, 3, 3, 7, 2, 0, 0, 1, 0);
    reset = 1'b1;                      chk("rst_pre", pk(1, 0, 0, 0, 0, 0, 1));
    drv(0, 0, 3, 3, 7, 2, 0, 0, 1, 0);
    reset = 1'b0;                      chk("rst_clear", pk(0, 0, 0, 0, 0, 0, 0));
    drv(0, 0, 3, 3, 7, 2, 0, 0, 1, 0); chk("rst_stay", pk(0, 0, 0, 0, 0, 0, 0));
    nops(3);

    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
